// File: rtl/sort_pkg.sv
// Shared definitions for the sorting block and its sorted_search consumer:
// vector geometry, element type and the search controller states.
package sort_pkg;

  localparam int SORT_N      = 6;
  localparam int IDX_W       = 3;
  localparam int SORT_DATA_W = 8;

  typedef logic [SORT_DATA_W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/sorted_search.sv
// Fixed-latency lower-bound binary search over a captured six-entry sorted
// vector; also reports whether the captured vector was out of order.
module sorted_search
  import sort_pkg::*;
#(
  parameter int DATA_W = SORT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  input  logic [DATA_W-1:0] in_data_4,
  input  logic [DATA_W-1:0] in_data_5,
  input  logic [DATA_W-1:0] key,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [IDX_W-1:0]  index,
  output logic              unsorted
);

  // lo/hi span 0..SORT_N and their sum must not wrap, hence one extra bit
  localparam int            BND_W   = IDX_W + 1;
  localparam logic [BND_W-1:0] HI_INIT = BND_W'(SORT_N);
  localparam logic [BND_W-1:0] ONE_B   = BND_W'(1);
  localparam logic [1:0]    LAST_IT = 2'd2;

  logic [DATA_W-1:0] in_vec_s [SORT_N];
  logic [DATA_W-1:0] arr_r    [SORT_N];
  logic [DATA_W-1:0] key_r;
  logic [BND_W-1:0]  lo_r;
  logic [BND_W-1:0]  hi_r;
  logic [1:0]        cnt_r;
  state_t            state_r;

  logic [BND_W-1:0]  mid_s;
  logic [BND_W-1:0]  lo_nxt_s;
  logic [BND_W-1:0]  hi_nxt_s;
  logic              found_s;
  logic              unsorted_s;

  assign in_vec_s[0] = in_data_0;
  assign in_vec_s[1] = in_data_1;
  assign in_vec_s[2] = in_data_2;
  assign in_vec_s[3] = in_data_3;
  assign in_vec_s[4] = in_data_4;
  assign in_vec_s[5] = in_data_5;

  // One bisection step; bounds freeze once the interval is empty.
  always_comb begin
    mid_s    = (lo_r + hi_r) >> 1;
    lo_nxt_s = lo_r;
    hi_nxt_s = hi_r;
    if (lo_r < hi_r) begin
      if (arr_r[mid_s[IDX_W-1:0]] < key_r) begin
        lo_nxt_s = mid_s + ONE_B;
      end else begin
        hi_nxt_s = mid_s;
      end
    end else begin
      lo_nxt_s = lo_r;
      hi_nxt_s = hi_r;
    end
  end

  // Result terms: match at the final lower bound, and adjacent-pair order check.
  always_comb begin
    found_s    = 1'b0;
    unsorted_s = 1'b0;
    if (lo_r < HI_INIT) begin
      found_s = (arr_r[lo_r[IDX_W-1:0]] == key_r);
    end else begin
      found_s = 1'b0;
    end
    for (int i = 0; i < SORT_N - 1; i++) begin
      unsorted_s = unsorted_s | (arr_r[i] > arr_r[i+1]);
    end
  end

  // Controller: capture, three bisection steps, then one result cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      key_r    <= '0;
      lo_r     <= '0;
      hi_r     <= '0;
      cnt_r    <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      index    <= '0;
      unsorted <= 1'b0;
      for (int i = 0; i < SORT_N; i++) begin
        arr_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int i = 0; i < SORT_N; i++) begin
              arr_r[i] <= in_vec_s[i];
            end
            key_r   <= key;
            lo_r    <= '0;
            hi_r    <= HI_INIT;
            cnt_r   <= 2'd0;
            busy    <= 1'b1;
            state_r <= SEARCH;
          end else begin
            busy <= 1'b0;
          end
        end
        SEARCH: begin
          lo_r  <= lo_nxt_s;
          hi_r  <= hi_nxt_s;
          cnt_r <= cnt_r + 2'd1;
          if (cnt_r == LAST_IT) begin
            state_r <= RESULT;
          end else begin
            state_r <= SEARCH;
          end
        end
        RESULT: begin
          index    <= lo_r[IDX_W-1:0];
          found    <= found_s;
          unsorted <= unsorted_s;
          done     <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_search.sv
// Self-checking bench for sorted_search: directed cases, throughput, reset
// abort and randomized sorted vectors against a linear lower-bound model.
module tb_sorted_search;
  import sort_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  elem_t      d [SORT_N];
  elem_t      key;
  logic       busy;
  logic       done;
  logic       found;
  logic [2:0] index;
  logic       unsorted;

  int checks = 0;
  int errors = 0;

  sorted_search #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data_0 (d[0]),
    .in_data_1 (d[1]),
    .in_data_2 (d[2]),
    .in_data_3 (d[3]),
    .in_data_4 (d[4]),
    .in_data_5 (d[5]),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .index     (index),
    .unsorted  (unsorted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int a0, input int a1, input int a2,
                         input int a3, input int a4, input int a5, input int k);
    d[0] = 8'(a0); d[1] = 8'(a1); d[2] = 8'(a2);
    d[3] = 8'(a3); d[4] = 8'(a4); d[5] = 8'(a5);
    key  = 8'(k);
  endtask

  // Launches one search from IDLE, scrambles inputs after capture, checks result.
  task automatic run_search(input string tag, input int exp_idx,
                            input logic exp_found, input logic exp_uns);
    int lat;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".busy_e0"}, 32'(busy), 32'd1);
    for (int i = 0; i < SORT_N; i++) d[i] = 8'($urandom);
    key = 8'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd4);
    check({tag, ".found"}, 32'(found), 32'(exp_found));
    check({tag, ".index"}, 32'(index), 32'(exp_idx));
    check({tag, ".unsorted"}, 32'(unsorted), 32'(exp_uns));
    check({tag, ".busy_e4"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, ".done_e5"}, 32'(done), 32'd0);
    check({tag, ".busy_e5"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int   ref_idx;
    logic ref_found;
    int   vals [SORT_N];
    int   tmp;
    int   ndone;
    int   done_at [2];

    rst_n = 1'b0;
    start = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.found", 32'(found), 32'd0);
    check("rst.index", 32'(index), 32'd0);
    check("rst.unsorted", 32'(unsorted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    set_vec(3, 7, 7, 7, 20, 200, 7);
    run_search("dup7", 1, 1'b1, 1'b0);
    set_vec(3, 7, 7, 7, 20, 200, 255);
    run_search("k255", 6, 1'b0, 1'b0);
    set_vec(3, 7, 7, 7, 20, 200, 0);
    run_search("k0", 0, 1'b0, 1'b0);
    set_vec(3, 7, 7, 7, 20, 200, 10);
    run_search("k10", 4, 1'b0, 1'b0);
    // bisection: mid=3 (6<9) lo=4, mid=5 (8<9) lo=6, then frozen
    set_vec(9, 4, 5, 6, 7, 8, 9);
    run_search("unsorted", 6, 1'b0, 1'b1);

    // start held for ten edges: accepts at E0 and E5 only
    set_vec(3, 7, 7, 7, 20, 200, 7);
    ndone = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) set_vec(3, 7, 7, 7, 20, 200, 255);
      if (k == 9) start = 1'b0;
      if (done === 1'b1) begin
        if (ndone < 2) done_at[ndone] = k;
        ndone++;
        if (ndone == 1) begin
          check("hold.first_index", 32'(index), 32'd1);
          check("hold.first_found", 32'(found), 32'd1);
        end else begin
          check("hold.second_index", 32'(index), 32'd6);
          check("hold.second_found", 32'(found), 32'd0);
        end
      end
    end
    check("hold.done_count", 32'(ndone), 32'd2);
    check("hold.first_at", 32'(done_at[0]), 32'd4);
    check("hold.second_at", 32'(done_at[1]), 32'd9);

    // reset during the second iteration aborts with no done
    set_vec(3, 7, 7, 7, 20, 200, 7);
    run_search("pre_abort", 1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.found", 32'(found), 32'd0);
    check("abort.index", 32'(index), 32'd0);
    check("abort.unsorted", 32'(unsorted), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);
    set_vec(3, 7, 7, 7, 20, 200, 10);
    run_search("post_abort", 4, 1'b0, 1'b0);

    // random sorted vectors against linear lower-bound scan
    for (int it = 0; it < 10000; it++) begin
      for (int i = 0; i < SORT_N; i++) vals[i] = int'($urandom_range(0, 60));
      if (it % 16 == 0) vals[5] = 255;
      for (int p = 0; p < SORT_N - 1; p++)
        for (int q = 0; q < SORT_N - 1 - p; q++)
          if (vals[q] > vals[q+1]) begin
            tmp = vals[q]; vals[q] = vals[q+1]; vals[q+1] = tmp;
          end
      tmp = int'($urandom_range(0, 70));
      if (it % 23 == 0) tmp = 255;
      set_vec(vals[0], vals[1], vals[2], vals[3], vals[4], vals[5], tmp);
      ref_idx = SORT_N;
      ref_found = 1'b0;
      for (int i = SORT_N - 1; i >= 0; i--) begin
        if (vals[i] >= tmp) ref_idx = i;
        if (vals[i] == tmp) ref_found = 1'b1;
      end
      run_search("rand", ref_idx, ref_found, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
